// File: rtl/mac_tx_arb_if.sv
// Bundle between the frame sources, mac_encode and the transmit arbiter.
// The arbiter uses the slave modport; the sources/encoder side uses master.
interface mac_tx_arb_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0]      ch_req;
    logic [48*N_CH-1:0]   ch_dest;
    logic [16*N_CH-1:0]   ch_ethertype;
    logic [8*N_CH-1:0]    ch_data;
    logic [N_CH-1:0]      ch_valid;
    logic [N_CH-1:0]      ch_last;
    logic [N_CH-1:0]      ch_ready;
    logic [N_CH-1:0]      ch_grant;
    logic                 mac_send_next;
    logic                 mac_en;
    logic [47:0]          mac_dest;
    logic [15:0]          mac_ethertype;
    logic [7:0]           mac_payload;
    logic                 frame_done;
    logic                 frame_abort;
    logic                 busy;

    modport master (
        output ch_req, ch_dest, ch_ethertype, ch_data, ch_valid, ch_last, mac_send_next,
        input  ch_ready, ch_grant, mac_en, mac_dest, mac_ethertype, mac_payload,
               frame_done, frame_abort, busy
    );

    modport slave (
        input  ch_req, ch_dest, ch_ethertype, ch_data, ch_valid, ch_last, mac_send_next,
        output ch_ready, ch_grant, mac_en, mac_dest, mac_ethertype, mac_payload,
               frame_done, frame_abort, busy
    );
endinterface

// File: rtl/mac_tx_arb.sv
// Round-robin transmit arbiter feeding a single mac_encode: one channel per frame,
// payload streamed on send_next, underrun abort and a fixed inter-frame hold-off.
module mac_tx_arb #(
    parameter int N_CH       = 2,
    parameter int TIMEOUT    = 64,
    parameter int IFG_CYCLES = 12
) (
    input  logic         clk,
    input  logic         rst,
    mac_tx_arb_if.slave  bus
);
    localparam int IFG_EFF = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam int GAP_W   = $clog2(IFG_EFF + 1);
    localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_EFF - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [TO_W-1:0]   underrun_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [N_CH-1:0]   hi_mask;
    logic [N_CH-1:0]   req_sel;
    logic [PTR_W-1:0]  win_idx;
    logic [47:0]       win_dest;
    logic [15:0]       win_type;
    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;
    logic              xfer;
    logic              empty_slot;
    logic [PTR_W-1:0]  next_ptr;

    // Prefer requesters at or above the pointer; fall back to the lowest one to wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hi_mask  = '0;
        win_idx  = '0;
        win_dest = '0;
        win_type = '0;
        for (int i = 0; i < N_CH; i++) begin
            hi_mask[i] = (PTR_W'(i) >= rr_ptr);
        end
        req_sel = ((bus.ch_req & hi_mask) != '0) ? (bus.ch_req & hi_mask) : bus.ch_req;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_sel[i]) win_idx = PTR_W'(i);
        end
        for (int i = 0; i < N_CH; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_dest = bus.ch_dest[48*i +: 48];
                win_type = bus.ch_ethertype[16*i +: 16];
            end
        end
    end

    // The one-hot grant is only non-zero in STREAM, so it doubles as the payload mux select.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.ch_grant[i]) begin
                g_valid = bus.ch_valid[i];
                g_last  = bus.ch_last[i];
                g_data  = bus.ch_data[8*i +: 8];
            end
        end
        xfer            = (state == STREAM) && bus.mac_send_next && g_valid;
        empty_slot      = (state == STREAM) && bus.mac_send_next && !g_valid;
        bus.ch_ready    = xfer ? bus.ch_grant : '0;
        bus.mac_payload = xfer ? g_data : 8'h00;
    end

    assign next_ptr = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + 1'b1;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state             <= IDLE;
            bus.mac_en        <= 1'b0;
            bus.ch_grant      <= '0;
            bus.mac_dest      <= '0;
            bus.mac_ethertype <= '0;
            bus.frame_done    <= 1'b0;
            bus.frame_abort   <= 1'b0;
            rr_ptr            <= '0;
            gnt_idx           <= '0;
            underrun_cnt      <= '0;
            gap_cnt           <= '0;
        end else begin
            bus.frame_done  <= 1'b0;
            bus.frame_abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ch_req != '0) begin
                        state             <= STREAM;
                        bus.mac_en        <= 1'b1;
                        bus.ch_grant      <= N_CH'(1) << win_idx;
                        gnt_idx           <= win_idx;
                        bus.mac_dest      <= win_dest;
                        bus.mac_ethertype <= win_type;
                        underrun_cnt      <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        underrun_cnt <= '0;
                    end else if (empty_slot) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                    // Both exits hand priority to the next channel and enter the hold-off.
                    if ((xfer && g_last) || (empty_slot && underrun_cnt == TO_LAST)) begin
                        state           <= GAP;
                        bus.mac_en      <= 1'b0;
                        bus.ch_grant    <= '0;
                        rr_ptr          <= next_ptr;
                        gap_cnt         <= '0;
                        bus.frame_done  <= xfer;
                        bus.frame_abort <= !xfer;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_tx_arb.sv
// Scoreboard bench for mac_tx_arb: stimulus queues expected grants, bytes and frame ends;
// a negedge monitor pops and compares whenever the arbiter presents them.
module tb_mac_tx_arb;
    localparam int N_CH       = 2;
    localparam int TIMEOUT    = 4;
    localparam int IFG_CYCLES = 12;

    localparam logic [47:0] D0  = 48'h001122334455;
    localparam logic [15:0] T0  = 16'h0806;
    localparam logic [47:0] D1  = 48'hA1A2A3A4A5A6;
    localparam logic [15:0] T1  = 16'h0800;
    localparam logic [47:0] D0B = 48'hCAFEF00D0001;
    localparam logic [15:0] T0B = 16'h86DD;

    localparam int END_DONE  = 0;
    localparam int END_ABORT = 1;
    localparam int END_NONE  = 2;

    typedef struct {
        int         ch;
        logic [7:0] b;
    } byte_exp_t;

    typedef struct {
        int          ch;
        logic [47:0] dest;
        logic [15:0] etype;
    } grant_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_tx_arb_if #(.N_CH(N_CH)) bus ();

    mac_tx_arb #(
        .N_CH      (N_CH),
        .TIMEOUT   (TIMEOUT),
        .IFG_CYCLES(IFG_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    byte_exp_t  exp_bytes[$];
    grant_exp_t exp_grants[$];
    int         exp_ends[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [63:0] w, input int k);
        logic [63:0] s;
        s = (k < 8) ? (w << (8 * k)) : 64'h0;
        return s[63:56];
    endfunction

    // Source model: frame bytes left-aligned in a 64-bit word; position tracks accepted bytes.
    logic [63:0]     src_bytes[N_CH];
    int              src_len[N_CH];
    int              src_stall[N_CH];
    int              src_base[N_CH];
    logic            req_on[N_CH];
    int              xfer_cnt[N_CH];
    logic [N_CH-1:0] rdy_seen = '0;
    int              sn_mode = 0;
    int              cyc = 0;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            src_bytes[i] = '0;
            src_len[i]   = 0;
            src_stall[i] = 0;
            src_base[i]  = 0;
            req_on[i]    = 1'b0;
            xfer_cnt[i]  = 0;
        end
    end

    always_comb begin
        int pos;
        pos          = 0;
        bus.ch_req   = '0;
        bus.ch_valid = '0;
        bus.ch_last  = '0;
        bus.ch_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = xfer_cnt[i] - src_base[i];
            bus.ch_req[i]        = req_on[i] && (pos < src_len[i]);
            bus.ch_valid[i]      = req_on[i] && (pos < src_len[i]) && (pos < src_stall[i]);
            bus.ch_last[i]       = (pos == src_len[i] - 1);
            bus.ch_data[8*i +: 8] = byte_at(src_bytes[i], pos);
        end
    end

    always @(negedge clk) rdy_seen = bus.ch_ready;

    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rdy_seen[i]) xfer_cnt[i] <= xfer_cnt[i] + 1;
        end
    end

    initial begin
        bus.mac_send_next = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.mac_send_next = (sn_mode == 0) || (sn_mode == 1 && (cyc % 3) == 0);
        end
    end

    task automatic load(input int ch, input logic [63:0] bytes, input int len, input int stall);
        src_bytes[ch] = bytes;
        src_len[ch]   = len;
        src_stall[ch] = stall;
        src_base[ch]  = xfer_cnt[ch];
        req_on[ch]    = 1'b1;
    endtask

    task automatic clear(input int ch);
        req_on[ch]  = 1'b0;
        src_len[ch] = 0;
    endtask

    task automatic expect_frame(input int ch, input logic [47:0] dest, input logic [15:0] etype,
                                input logic [63:0] bytes, input int n, input int end_kind);
        exp_grants.push_back('{ch, dest, etype});
        for (int k = 0; k < n; k++) exp_bytes.push_back('{ch, byte_at(bytes, k)});
        if (end_kind != END_NONE) exp_ends.push_back(end_kind);
    endtask

    // Monitor: compares every grant, accepted byte and frame-end pulse against the queues.
    logic       mac_en_q = 1'b0;
    grant_exp_t g_exp;
    byte_exp_t  b_exp;
    int         e_exp;

    always @(negedge clk) begin
        if (bus.mac_en && !mac_en_q) begin
            if (exp_grants.size() == 0) begin
                check("grant_unexpected", 1, 0);
            end else begin
                g_exp = exp_grants.pop_front();
                check("grant_onehot", bus.ch_grant, 64'(N_CH'(1) << g_exp.ch));
                check("grant_dest", bus.mac_dest, g_exp.dest);
                check("grant_type", bus.mac_ethertype, g_exp.etype);
            end
        end
        mac_en_q = bus.mac_en;
        if (bus.ch_ready != '0) begin
            if (exp_bytes.size() == 0) begin
                check("byte_unexpected", 1, 0);
            end else begin
                b_exp = exp_bytes.pop_front();
                check("byte_ready", bus.ch_ready, 64'(N_CH'(1) << b_exp.ch));
                check("byte_payload", bus.mac_payload, b_exp.b);
            end
        end else if (bus.mac_en) begin
            check("payload_idle_zero", bus.mac_payload, 0);
        end
        if (bus.frame_done || bus.frame_abort) begin
            if (exp_ends.size() == 0) begin
                check("end_unexpected", {bus.frame_done, bus.frame_abort}, 0);
            end else begin
                e_exp = exp_ends.pop_front();
                check("end_kind", {bus.frame_done, bus.frame_abort},
                      (e_exp == END_DONE) ? 2'b10 : 2'b01);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_mac_en"}, bus.mac_en, 0);
        check({tag, "_grant"}, bus.ch_grant, 0);
        check({tag, "_dest"}, bus.mac_dest, 0);
        check({tag, "_type"}, bus.mac_ethertype, 0);
        check({tag, "_done"}, bus.frame_done, 0);
        check({tag, "_abort"}, bus.frame_abort, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ready"}, bus.ch_ready, 0);
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.frame_done || bus.frame_abort) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n >= 200), 0);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (!bus.mac_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n >= 100), 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n >= 100), 0);
    endtask

    initial begin
        int n;
        logic [63:0] t2b[4];
        t2b[0] = 64'h1011_0000_0000_0000;
        t2b[1] = 64'h2021_0000_0000_0000;
        t2b[2] = 64'h1213_0000_0000_0000;
        t2b[3] = 64'h2223_0000_0000_0000;
        bus.ch_dest      = {D1, D0};
        bus.ch_ethertype = {T1, T0};

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Single frame on ch0, send_next every cycle.
        @(negedge clk);
        expect_frame(0, D0, T0, 64'hDEADBEEF_00000000, 4, END_DONE);
        load(0, 64'hDEADBEEF_00000000, 4, 99);
        check("t1_en_before", bus.mac_en, 0);
        @(negedge clk);
        check("t1_en_latency", bus.mac_en, 1);
        wait_end("t1_end");
        check("t1_en_low_at_done", bus.mac_en, 0);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_cycles", n, IFG_CYCLES);

        // Fairness after reset: ch0 first, then strict alternation with both requesting.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_frame(0, D0, T0, t2b[0], 2, END_DONE);
        expect_frame(1, D1, T1, t2b[1], 2, END_DONE);
        expect_frame(0, D0, T0, t2b[2], 2, END_DONE);
        expect_frame(1, D1, T1, t2b[3], 2, END_DONE);
        load(0, t2b[0], 2, 99);
        load(1, t2b[1], 2, 99);
        for (int f = 0; f < 4; f++) begin
            wait_end("t2_end");
            if (f < 2) load(f % 2, t2b[f + 2], 2, 99);
            if (f < 3) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.mac_en && n < 100);
                check("t2_gap_to_grant", n, IFG_CYCLES + 1);
            end
        end
        wait_idle("t2_idle");

        // Underrun on ch1: one byte then valid drops while send_next stays high.
        expect_frame(1, D1, T1, 64'h31_00000000000000, 1, END_ABORT);
        expect_frame(0, D0, T0, 64'h4041_000000000000, 2, END_DONE);
        expect_frame(1, D1, T1, 64'h3334_000000000000, 2, END_DONE);
        load(1, 64'h3132_3334_0000_0000, 4, 1);
        wait_grant("t3_grant");
        load(0, 64'h4041_000000000000, 2, 99);
        n = 0;
        while (!bus.frame_abort && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_abort_cycles", n, 5);
        check("t3_en_low_at_abort", bus.mac_en, 0);
        check("t3_grant_low_at_abort", bus.ch_grant, 0);
        load(1, 64'h3334_000000000000, 2, 99);
        wait_end("t3_ch0_end");
        wait_end("t3_ch1_end");
        wait_idle("t3_idle");

        // Sparse send_next plus field latch: ch0's fields change mid-frame.
        sn_mode = 1;
        expect_frame(0, D0, T0, 64'h5152_5354_0000_0000, 4, END_DONE);
        load(0, 64'h5152_5354_0000_0000, 4, 99);
        wait_grant("t4_grant");
        bus.ch_dest[47:0]      = D0B;
        bus.ch_ethertype[15:0] = T0B;
        n = 0;
        while (bus.mac_en && n < 100) begin
            check("t4_dest_held", bus.mac_dest, D0);
            check("t4_type_held", bus.mac_ethertype, T0);
            check("t4_ready_tracks_sn", bus.ch_ready[0], bus.mac_send_next);
            @(negedge clk);
            n++;
        end
        sn_mode = 0;
        wait_idle("t4_idle");

        // Mid-frame reset on ch1 during byte 2; the new grant after release goes to ch0.
        expect_frame(1, D1, T1, 64'h6162_0000_0000_0000, 2, END_NONE);
        expect_frame(0, D0B, T0B, 64'h7172_000000000000, 2, END_DONE);
        expect_frame(1, D1, T1, 64'h8182_000000000000, 2, END_DONE);
        load(1, 64'h6162_6364_0000_0000, 4, 99);
        wait_grant("t5_grant");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("t5_reset");
        clear(1);
        rst = 1'b1;
        load(0, 64'h7172_000000000000, 2, 99);
        load(1, 64'h8182_000000000000, 2, 99);
        wait_end("t5_ch0_end");
        wait_end("t5_ch1_end");
        wait_idle("t5_idle");
        repeat (2) @(negedge clk);

        check("left_grants", exp_grants.size(), 0);
        check("left_bytes", exp_bytes.size(), 0);
        check("left_ends", exp_ends.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mac_tx_arb.md
Name: mac_tx_arb

Overview:
- N-channel transmit arbiter between frame sources (ARP encoder, future IP/UDP encoders) and the single mac_encode instance.
- Grants mac_encode to one channel per frame with round-robin fairness.
- Latches that channel's destination MAC and ethertype, then streams its payload bytes on mac_encode's send_next strobe.
- Adds underrun timeout/abort and a programmable inter-frame hold-off.

Parameters:
N_CH, 2, number of source channels (1..8)
TIMEOUT, 64, consecutive send_next-without-valid cycles before a frame is aborted (>=1)
IFG_CYCLES, 12, idle cycles enforced after each frame end/abort (0 treated as 1)

Ports:
clk  in  1  system clock (same domain as mac_encode)
rst  in  1  synchronous reset, active-low
ch_req  in  N_CH  per-channel frame request, level, held until frame done/abort
ch_dest  in  48*N_CH  per-channel destination MAC, channel i at [48*i +: 48]
ch_ethertype  in  16*N_CH  per-channel ethertype, channel i at [16*i +: 16]
ch_data  in  8*N_CH  per-channel payload byte
ch_valid  in  N_CH  payload byte valid
ch_last  in  N_CH  marks final payload byte
ch_ready  out  N_CH  byte accepted this cycle (combinational)
ch_grant  out  N_CH  one-hot registered grant
mac_send_next  in  1  mac_encode requests next payload byte
mac_en  out  1  frame enable to mac_encode
mac_dest  out  48  latched destination MAC
mac_ethertype  out  16  latched ethertype
mac_payload  out  8  payload byte to mac_encode (combinational)
frame_done  out  1  1-cycle pulse on accepted last byte
frame_abort  out  1  1-cycle pulse on timeout abort
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; mac_en=0, ch_grant=0, mac_dest=0, mac_ethertype=0, frame_done=0, frame_abort=0; RR pointer=0 (ch0 highest priority first). Applies mid-frame; the partial frame is dropped with no abort pulse.
- States: IDLE, STREAM, GAP.
- IDLE:
  - If any ch_req, winner = first requesting channel at or after the RR pointer, wrapping modulo N_CH.
  - Next edge: ch_grant=onehot(winner), mac_dest/mac_ethertype latched from the winner's fields, mac_en=1, state=STREAM. Latency from req to mac_en is 1 cycle.
- STREAM, g = granted channel:
  - ch_ready[g] = mac_send_next & ch_valid[g]; all other ch_ready = 0.
  - mac_payload = ch_data[g] when ch_ready[g], else 8'h00.
  - Transfer happens when ch_ready[g]=1. It resets the underrun counter.
  - Transfer with ch_last[g]: next edge mac_en=0, frame_done=1 for 1 cycle, ch_grant=0, RR pointer=(g+1) mod N_CH, state=GAP.
  - mac_send_next & ~ch_valid[g] increments the underrun counter. When the count reaches TIMEOUT: next edge mac_en=0, frame_abort=1 for 1 cycle, ch_grant=0, pointer=(g+1) mod N_CH, state=GAP.
  - Cycles without mac_send_next do not change the counter.
  - Changes to ch_req/ch_dest/ch_ethertype during STREAM are ignored. Dropping ch_req[g] mid-frame does not end the frame.
- GAP:
  - Counter counts max(IFG_CYCLES,1) cycles; then state=IDLE.
  - Requests are not arbitrated during GAP, so the earliest next mac_en is IFG+1 cycles after the frame_done/abort edge.
- Simultaneous requests are resolved only by the RR pointer. A channel that just finished has lowest priority next.
- Counter widths are $clog2(TIMEOUT+1) and $clog2(IFG_CYCLES+1). No wrap-around is possible because they saturate at the terminal value.
- N_CH=1 degenerates to a pass-through: the pointer is always 0.

Test Plan:
- Single frame: ch0 req, dest=48'h001122334455, type=16'h0806, 4 bytes DE AD BE EF with last on EF, send_next every cycle -> mac_en rises 1 cycle after req; mac_payload shows DE,AD,BE,EF; frame_done one cycle later; mac_en=0; busy until 12 idle cycles pass.
- Fairness, N_CH=2: both req continuously, 2-byte frames -> grants alternate ch0,ch1,ch0,ch1. After reset ch0 is granted first.
- Underrun, TIMEOUT=4: ch1 granted, sends 1 byte then drops valid with send_next high -> frame_abort pulse on the 4th empty send_next; mac_en=0; no frame_done; the next grant goes to ch0 if requesting.
- Sparse send_next: send_next every 3rd cycle, valid always high -> exactly one ch_ready per send_next; underrun counter stays 0; byte order is preserved.
- Mid-frame reset: assert rst=0 for 1 cycle during byte 2 -> all outputs return to reset values next edge; no done or abort pulse; a new request after release goes to ch0.
- Field latch: change ch_dest[g] during STREAM -> mac_dest is unchanged until the next grant.
